fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Producer side of the fetch→decode pipeline-register interface in the Y86-64 pipelined core. Generates every f_* field the decode register latches: f_stat, f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP.
- Owns the F-stage predicted-PC register and selects the fetch PC: predicted PC, mispredicted-branch recovery, or return address.
- Parses the instruction bytes returned by instruction memory.
- Runs a small fetch FSM covering post-reset idle and halt/exception parking.

Parameters:
- RESET_PC, 64'h0, value loaded into F_predPC on reset.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- F_stall  in  1  hold F_predPC and FSM state this cycle.
- M_icode  in  4  icode in memory stage.
- M_cnd  in  1  branch condition resolved in memory stage.
- M_valA  in  64  fall-through PC of the mispredicted jXX.
- W_icode  in  4  icode in writeback stage.
- W_valM  in  64  return address popped by ret.
- imem_bytes  in  80  10 bytes at f_pc; byte0 in [7:0], little-endian.
- imem_error  in  1  f_pc out of range.
- f_pc  out  64  selected fetch PC (to instruction memory).
- f_stat  out  3  AOK=1, HLT=2, ADR=3, INS=4.
- f_icode, f_ifun, f_rA, f_rB  out  4 each  decoded fields.
- f_valC, f_valP  out  64 each  constant word and next sequential PC.

Behaviour:
- Reset (async, rst_n=0):
  - F_predPC=RESET_PC; state=IDLE.
  - All f_* outputs equal the NOP bubble: stat=AOK, icode=1, ifun=0, rA=rB=F, valC=0, valP=RESET_PC.
- PC select (combinational), in priority order:
  - M_icode==7 && !M_cnd → M_valA.
  - else W_icode==9 → W_valM.
  - else F_predPC.
  - Both redirects asserted in the same cycle: the jXX redirect wins.
- Parse:
  - icode=byte0[7:4], ifun=byte0[3:0].
  - need_regids for icodes 2,3,4,5,6,A,B: rA=byte1[7:4], rB=byte1[3:0]; otherwise rA=rB=F.
  - need_valC for icodes 3,4,5,7,8: valC=bytes[2..9] if need_regids, else bytes[1..8]; otherwise valC=0.
  - valP = f_pc + 1 + need_regids + 8·need_valC, mod 2^64 (wrap allowed).
- Validity:
  - icode > B → INS.
  - ifun > 3 for icode 6 → INS; ifun > 6 for icodes 2/7 → INS; ifun ≠ 0 for any other icode → INS.
  - imem_error → ADR, and forces icode=1, ifun=0 (ADR overrides INS).
  - icode 0 → HLT.
  - Otherwise AOK.
- Prediction: next F_predPC = valC for icodes 7 and 8, else valP. Written on posedge when !F_stall and state==RUN.
- FSM (state and F_predPC update only when !F_stall):
  - IDLE: outputs bubble; unconditionally → RUN. F_predPC is unchanged.
  - RUN: outputs parsed fields. If f_stat ≠ AOK → HALTED, with F_predPC ← f_pc (park on the faulting instruction); else F_predPC ← prediction.
  - HALTED: outputs bubble with valP=F_predPC. A redirect (either PC-select condition true) → RUN, with f_pc taken from the redirect in that same cycle (parsed output, normal prediction update).
- F_stall=1: F_predPC and state held; f_* stay combinational from the current f_pc, so the decode register is free to ignore them.
- Latency: 0 cycles combinational from f_pc/imem_bytes to f_*; 1 cycle for the predicted-PC update.
- Reset mid-operation: immediate return to IDLE with bubble outputs.

Optional Feature:
- Macro FETCH_PERF_CNT_EN. When defined, adds:
  - output fetch_cnt [31:0]: increments on posedge when state==RUN, !F_stall and f_stat==AOK.
  - output stall_cnt [31:0]: increments on each posedge with F_stall=1.
  - Both wrap at 2^32 and reset to 0.
- When undefined, neither port nor counter exists.

Decomposition:
- Package y86_pkg: icode constants (HALT..POPQ), stat constants (AOK/HLT/ADR/INS), REG_NONE=4'hF, fetch FSM state enum.
- One sub-module, instr_split: purely combinational byte parse producing icode/ifun/rA/rB/valC/need_regids/need_valC.

Test Plan:
- Reset, release, imem at 0 = 30 F2 0A 00.. (irmovq $10,%rdx) → IDLE bubble for 1 cycle; next cycle f_icode=3, rB=2, valC=10, valP=10, stat=AOK.
- jXX at PC 0x20 with valC=0x100, then M_icode=7, M_cnd=0, M_valA=0x29 → predicted f_pc=0x100; redirect cycle f_pc=0x29.
- ret fetched, later W_icode=9, W_valM=0x40 while M_icode=7, M_cnd=0, M_valA=0x55 → f_pc=0x55 (jXX priority).
- Byte0=0xC0 → stat=INS, FSM HALTED, subsequent bubbles with valP=faulting PC; imem_error=1 → stat=ADR, icode=1.
- F_stall=1 for 3 cycles mid-stream → f_pc constant; FETCH_PERF_CNT_EN build shows stall_cnt+3, fetch_cnt unchanged.
- Assert rst_n=0 while HALTED → immediate bubble outputs, F_predPC=RESET_PC.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings and the fetch FSM state type.
package y86_pkg;
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [3:0] REG_NONE = 4'hF;

  typedef enum logic [1:0] {
    FS_IDLE   = 2'd0,
    FS_RUN    = 2'd1,
    FS_HALTED = 2'd2
  } fetch_state_e;

  function automatic logic has_regids(input logic [3:0] icode);
    return (icode == I_RRMOVQ) || (icode == I_IRMOVQ) || (icode == I_RMMOVQ) ||
           (icode == I_MRMOVQ) || (icode == I_OPQ) || (icode == I_PUSHQ) ||
           (icode == I_POPQ);
  endfunction

  function automatic logic has_valc(input logic [3:0] icode);
    return (icode == I_IRMOVQ) || (icode == I_RMMOVQ) || (icode == I_MRMOVQ) ||
           (icode == I_JXX) || (icode == I_CALL);
  endfunction
endpackage

// File: rtl/instr_split.sv
// Combinational split of the 10 instruction bytes into Y86-64 fields.
module instr_split
  import y86_pkg::*;
(
  input  logic [79:0] bytes_i,
  output logic [3:0]  icode_o,
  output logic [3:0]  ifun_o,
  output logic [3:0]  ra_o,
  output logic [3:0]  rb_o,
  output logic [63:0] valc_o,
  output logic        need_regids_o,
  output logic        need_valc_o
);
  always_comb begin
    icode_o       = bytes_i[7:4];
    ifun_o        = bytes_i[3:0];
    need_regids_o = has_regids(bytes_i[7:4]);
    need_valc_o   = has_valc(bytes_i[7:4]);
    ra_o          = need_regids_o ? bytes_i[15:12] : REG_NONE;
    rb_o          = need_regids_o ? bytes_i[11:8]  : REG_NONE;
    // The constant word follows the register byte when one is present.
    if (!need_valc_o)       valc_o = 64'd0;
    else if (need_regids_o) valc_o = bytes_i[79:16];
    else                    valc_o = bytes_i[71:8];
  end
endmodule

// File: rtl/fetch_stage.sv
// Y86-64 fetch stage: PC select, instruction parse, PC prediction and fetch FSM.
// Optional FETCH_PERF_CNT_EN adds fetch_cnt/stall_cnt performance counters.
module fetch_stage
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        F_stall,
  input  logic [3:0]  M_icode,
  input  logic        M_cnd,
  input  logic [63:0] M_valA,
  input  logic [3:0]  W_icode,
  input  logic [63:0] W_valM,
  input  logic [79:0] imem_bytes,
  input  logic        imem_error,
  output logic [63:0] f_pc,
  output logic [2:0]  f_stat,
  output logic [3:0]  f_icode,
  output logic [3:0]  f_ifun,
  output logic [3:0]  f_rA,
  output logic [3:0]  f_rB,
  output logic [63:0] f_valC,
  output logic [63:0] f_valP,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt,
`endif
  output logic [1:0]  dbg_state_o
);
  fetch_state_e state_q;
  logic [63:0]  pred_pc_q;

  logic [3:0]  raw_icode, raw_ifun, p_ra, p_rb;
  logic [63:0] p_valc, p_valp, pred_next;
  logic        need_regids, need_valc;
  logic        redirect_m, redirect_w, active, ifun_bad;
  logic [2:0]  p_stat;
  logic [3:0]  p_icode, p_ifun;

  instr_split u_split (
    .bytes_i       (imem_bytes),
    .icode_o       (raw_icode),
    .ifun_o        (raw_ifun),
    .ra_o          (p_ra),
    .rb_o          (p_rb),
    .valc_o        (p_valc),
    .need_regids_o (need_regids),
    .need_valc_o   (need_valc)
  );

  assign redirect_m = (M_icode == I_JXX) && !M_cnd;
  assign redirect_w = (W_icode == I_RET);

  always_comb begin
    if (redirect_m)      f_pc = M_valA;
    else if (redirect_w) f_pc = W_valM;
    else                 f_pc = pred_pc_q;
  end

  assign p_valp = f_pc + 64'd1 + {63'd0, need_regids} + (need_valc ? 64'd8 : 64'd0);

  always_comb begin
    case (raw_icode)
      I_OPQ:            ifun_bad = raw_ifun > 4'd3;
      I_RRMOVQ, I_JXX:  ifun_bad = raw_ifun > 4'd6;
      default:          ifun_bad = raw_ifun != 4'd0;
    endcase
    p_icode = raw_icode;
    p_ifun  = raw_ifun;
    // An unreachable PC masquerades as a nop so nothing downstream acts on garbage.
    if (imem_error) begin
      p_stat  = STAT_ADR;
      p_icode = I_NOP;
      p_ifun  = 4'd0;
    end else if (raw_icode > I_POPQ || ifun_bad) begin
      p_stat = STAT_INS;
    end else if (raw_icode == I_HALT) begin
      p_stat = STAT_HLT;
    end else begin
      p_stat = STAT_AOK;
    end
  end

  assign pred_next = (p_icode == I_JXX || p_icode == I_CALL) ? p_valc : p_valp;

  // A redirect while parked restarts fetch in that same cycle.
  assign active = (state_q == FS_RUN) ||
                  (state_q == FS_HALTED && (redirect_m || redirect_w));

  always_comb begin
    if (active) begin
      f_stat  = p_stat;
      f_icode = p_icode;
      f_ifun  = p_ifun;
      f_rA    = p_ra;
      f_rB    = p_rb;
      f_valC  = p_valc;
      f_valP  = p_valp;
    end else begin
      f_stat  = STAT_AOK;
      f_icode = I_NOP;
      f_ifun  = 4'd0;
      f_rA    = REG_NONE;
      f_rB    = REG_NONE;
      f_valC  = 64'd0;
      f_valP  = pred_pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FS_IDLE;
      pred_pc_q <= RESET_PC;
    end else if (!F_stall) begin
      case (state_q)
        FS_IDLE: state_q <= FS_RUN;
        FS_RUN, FS_HALTED: begin
          if (active) begin
            if (p_stat != STAT_AOK) begin
              state_q   <= FS_HALTED;
              pred_pc_q <= f_pc;
            end else begin
              state_q   <= FS_RUN;
              pred_pc_q <= pred_next;
            end
          end
        end
        default: state_q <= FS_IDLE;
      endcase
    end
  end

  assign dbg_state_o = state_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      if (state_q == FS_RUN && !F_stall && p_stat == STAT_AOK)
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (F_stall)
        stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; hand-computed expectations at each step.
module tb_fetch_stage;
  import y86_pkg::*;

  logic        clk, rst_n, F_stall, M_cnd, imem_error;
  logic [3:0]  M_icode, W_icode;
  logic [63:0] M_valA, W_valM;
  logic [79:0] imem_bytes;
  logic [63:0] f_pc, f_valC, f_valP;
  logic [2:0]  f_stat;
  logic [3:0]  f_icode, f_ifun, f_rA, f_rB;
  logic [1:0]  dbg_state;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt, stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  fetch_stage #(.RESET_PC(64'h0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .F_stall    (F_stall),
    .M_icode    (M_icode),
    .M_cnd      (M_cnd),
    .M_valA     (M_valA),
    .W_icode    (W_icode),
    .W_valM     (W_valM),
    .imem_bytes (imem_bytes),
    .imem_error (imem_error),
    .f_pc       (f_pc),
    .f_stat     (f_stat),
    .f_icode    (f_icode),
    .f_ifun     (f_ifun),
    .f_rA       (f_rA),
    .f_rB       (f_rB),
    .f_valC     (f_valC),
    .f_valP     (f_valP),
`ifdef FETCH_PERF_CNT_EN
    .fetch_cnt  (fetch_cnt),
    .stall_cnt  (stall_cnt),
`endif
    .dbg_state_o(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_f(input string s, input logic [2:0] st, input logic [3:0] ic,
                       input logic [3:0] fn, input logic [3:0] ra, input logic [3:0] rb,
                       input logic [63:0] vc, input logic [63:0] vp);
    chk({s, ".stat"},  {61'd0, f_stat}, {61'd0, st});
    chk({s, ".icode"}, {60'd0, f_icode}, {60'd0, ic});
    chk({s, ".ifun"},  {60'd0, f_ifun}, {60'd0, fn});
    chk({s, ".rA"},    {60'd0, f_rA}, {60'd0, ra});
    chk({s, ".rB"},    {60'd0, f_rB}, {60'd0, rb});
    chk({s, ".valC"},  f_valC, vc);
    chk({s, ".valP"},  f_valP, vp);
  endtask

  task automatic chk_pc(input string s, input logic [63:0] pc, input logic [1:0] st);
    chk({s, ".f_pc"},  f_pc, pc);
    chk({s, ".state"}, {62'd0, dbg_state}, {62'd0, st});
  endtask

  // Advance to the next falling edge, leaving redirect/stall inputs idle.
  task automatic next_step(input logic [79:0] bytes);
    @(negedge clk);
    F_stall = 1'b0; M_icode = I_NOP; M_cnd = 1'b0; M_valA = '0;
    W_icode = I_NOP; W_valM = '0; imem_error = 1'b0; imem_bytes = bytes;
  endtask

  initial begin
    rst_n = 1'b0; F_stall = 1'b0; M_icode = I_NOP; M_cnd = 1'b0; M_valA = '0;
    W_icode = I_NOP; W_valM = '0; imem_bytes = '0; imem_error = 1'b0;

    // Reset: bubble, predicted PC at RESET_PC.
    next_step(80'h0);
    #1;
    chk_f("rst", STAT_AOK, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0);
    chk_pc("rst", 64'h0, FS_IDLE);

    // Release: one IDLE bubble cycle while irmovq $10,%rdx sits at 0.
    next_step(80'h0AF230);
    rst_n = 1'b1;
    #1;
    chk_f("idle", STAT_AOK, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0);
    chk_pc("idle", 64'h0, FS_IDLE);

    next_step(80'h0AF230);
    #1;
    chk_f("irmov", STAT_AOK, 4'h3, 4'h0, 4'hF, 4'h2, 64'hA, 64'hA);
    chk_pc("irmov", 64'h0, FS_RUN);

    // jmp 0x20 at 0xA: predicted taken.
    next_step(80'h2070);
    #1;
    chk_f("jmp", STAT_AOK, 4'h7, 4'h0, 4'hF, 4'hF, 64'h20, 64'h13);
    chk_pc("jmp", 64'hA, FS_RUN);

    // jne 0x100 at 0x20.
    next_step(80'h010074);
    #1;
    chk_f("jne", STAT_AOK, 4'h7, 4'h4, 4'hF, 4'hF, 64'h100, 64'h29);
    chk_pc("jne", 64'h20, FS_RUN);

    // Predicted target, then mispredict recovery to 0x29 (ret there).
    next_step(80'h90);
    #1;
    chk_pc("pred", 64'h100, FS_RUN);
    M_icode = I_JXX; M_cnd = 1'b0; M_valA = 64'h29;
    #1;
    chk_pc("mispred", 64'h29, FS_RUN);
    chk_f("ret", STAT_AOK, 4'h9, 4'h0, 4'hF, 4'hF, 64'h0, 64'h2A);

    // Return address redirect alone.
    next_step(80'h10);
    W_icode = I_RET; W_valM = 64'h40;
    #1;
    chk_pc("retpc", 64'h40, FS_RUN);
    chk("retpc.valP", f_valP, 64'h41);

    // Both redirects: jXX wins.
    next_step(80'h10);
    W_icode = I_RET; W_valM = 64'h40;
    M_icode = I_JXX; M_cnd = 1'b0; M_valA = 64'h55;
    #1;
    chk_pc("prio", 64'h55, FS_RUN);
    chk("prio.valP", f_valP, 64'h56);

    // Taken branch in M is not a redirect; addq %rax,%rcx at 0x56.
    next_step(80'h0160);
    M_icode = I_JXX; M_cnd = 1'b1; M_valA = 64'h99;
    #1;
    chk_pc("taken", 64'h56, FS_RUN);
    chk_f("addq", STAT_AOK, 4'h6, 4'h0, 4'h0, 4'h1, 64'h0, 64'h58);

    // Three stalled cycles at 0x58: PC and state frozen.
    for (int i = 0; i < 3; i++) begin
      next_step(80'h10);
      F_stall = 1'b1;
      #1;
      chk_pc($sformatf("stall%0d", i), 64'h58, FS_RUN);
`ifdef FETCH_PERF_CNT_EN
      chk($sformatf("stall%0d.fetch_cnt", i), {32'd0, fetch_cnt}, 64'd7);
      chk($sformatf("stall%0d.stall_cnt", i), {32'd0, stall_cnt}, 64'(i));
`endif
    end

    next_step(80'h10);
    #1;
    chk_pc("unstall", 64'h58, FS_RUN);
    chk("unstall.valP", f_valP, 64'h59);
`ifdef FETCH_PERF_CNT_EN
    chk("unstall.fetch_cnt", {32'd0, fetch_cnt}, 64'd7);
    chk("unstall.stall_cnt", {32'd0, stall_cnt}, 64'd3);
`endif

    // Illegal icode 0xC at 0x59 parks the FSM.
    next_step(80'hC0);
    #1;
    chk_f("ins", STAT_INS, 4'hC, 4'h0, 4'hF, 4'hF, 64'h0, 64'h5A);
    chk_pc("ins", 64'h59, FS_RUN);

    for (int i = 0; i < 2; i++) begin
      next_step(80'h10);
      #1;
      chk_f($sformatf("halted%0d", i), STAT_AOK, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h59);
      chk_pc($sformatf("halted%0d", i), 64'h59, FS_HALTED);
    end

    // Redirect out of HALTED: parsed output in the same cycle.
    next_step(80'h10);
    M_icode = I_JXX; M_cnd = 1'b0; M_valA = 64'h70;
    #1;
    chk_f("restart", STAT_AOK, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h71);
    chk_pc("restart", 64'h70, FS_HALTED);

    // Address error at 0x71 overrides the fetched icode.
    next_step(80'h0AF230);
    imem_error = 1'b1;
    #1;
    chk("adr.stat", {61'd0, f_stat}, {61'd0, STAT_ADR});
    chk("adr.icode", {60'd0, f_icode}, 64'h1);
    chk("adr.ifun", {60'd0, f_ifun}, 64'h0);
    chk_pc("adr", 64'h71, FS_RUN);

    next_step(80'h10);
    #1;
    chk_f("adrpark", STAT_AOK, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h71);
    chk_pc("adrpark", 64'h71, FS_HALTED);

    // OPq with ifun 4 is illegal, seen on a restart cycle.
    next_step(80'h0164);
    M_icode = I_JXX; M_cnd = 1'b0; M_valA = 64'h80;
    #1;
    chk("opbad.stat", {61'd0, f_stat}, {61'd0, STAT_INS});
    chk("opbad.icode", {60'd0, f_icode}, 64'h6);
    chk("opbad.ifun", {60'd0, f_ifun}, 64'h4);
    chk("opbad.f_pc", f_pc, 64'h80);

    next_step(80'h10);
    #1;
    chk_pc("opbadpark", 64'h80, FS_HALTED);

    // halt via return redirect from HALTED.
    next_step(80'h00);
    W_icode = I_RET; W_valM = 64'h90;
    #1;
    chk_f("hlt", STAT_HLT, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h91);
    chk_pc("hlt", 64'h90, FS_HALTED);

    next_step(80'h10);
    #1;
    chk_pc("hltpark", 64'h90, FS_HALTED);
    chk("hltpark.valP", f_valP, 64'h90);

    // Asynchronous reset while parked.
    #2;
    rst_n = 1'b0;
    #1;
    chk_f("rst2", STAT_AOK, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0);
    chk_pc("rst2", 64'h0, FS_IDLE);
`ifdef FETCH_PERF_CNT_EN
    chk("rst2.fetch_cnt", {32'd0, fetch_cnt}, 64'd0);
    chk("rst2.stall_cnt", {32'd0, stall_cnt}, 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
